// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity frame checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: deserialises DATA_BITS data bits (LSB first),
// checks the trailing parity bit and counts parity errors.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 sof,
    input  logic                 odd_mode,
    input  logic                 clr_cnt,
    output logic                 z,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic                 sync_err,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int unsigned     CW   = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]   LAST = CW'(DATA_BITS);

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0]   r_data, w_data_nxt;
    logic                   r_mode, w_mode_nxt;
    logic                   r_z, w_z_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_perr, w_perr_nxt;
    logic                   r_serr, w_serr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_mode  <= PAR_EVEN;
            r_z     <= 1'b0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
            r_serr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_mode  <= w_mode_nxt;
            r_z     <= w_z_nxt;
            r_done  <= w_done_nxt;
            r_perr  <= w_perr_nxt;
            r_serr  <= w_serr_nxt;
        end
    end

    // Right shift with new bit at the MSB so bit k ends in position k.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_mode_nxt  = r_mode;
        w_z_nxt     = r_z;
        w_done_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
        w_serr_nxt  = 1'b0;
        if (bit_valid) begin
            if (sof) begin
                w_serr_nxt                 = (r_state != IDLE);
                w_mode_nxt                 = odd_mode;
                w_shift_nxt                = '0;
                w_shift_nxt[DATA_BITS-1]   = bit_in;
                w_z_nxt                    = bit_in;
                w_cnt_nxt                  = CW'(1);
                w_state_nxt                = (DATA_BITS == 1) ? PARITY : DATA;
            end else begin
                case (r_state)
                    DATA: begin
                        w_shift_nxt               = r_shift >> 1;
                        w_shift_nxt[DATA_BITS-1]  = bit_in;
                        w_z_nxt                   = r_z ^ bit_in;
                        w_cnt_nxt                 = r_cnt + CW'(1);
                        if (w_cnt_nxt == LAST) begin
                            w_state_nxt = PARITY;
                        end
                    end
                    PARITY: begin
                        w_perr_nxt  = (bit_in != (r_z ^ r_mode));
                        w_done_nxt  = 1'b1;
                        w_data_nxt  = r_shift;
                        w_z_nxt     = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        z          = r_z;
        data_out   = r_data;
        frame_done = r_done;
        parity_err = r_perr;
        sync_err   = r_serr;
    end

    // Increment on the same edge that registers parity_err.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_perr_nxt),
        .i_clr (clr_cnt),
        .o_cnt (err_cnt)
    );

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed self-checking bench for parity_frame_checker (DATA_BITS=8, CNT_W=4).
module tb_parity_frame_checker;

    localparam int unsigned DB = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bit_in;
    logic          bit_valid;
    logic          sof;
    logic          odd_mode;
    logic          clr_cnt;
    logic          z;
    logic [DB-1:0] data_out;
    logic          frame_done;
    logic          parity_err;
    logic          sync_err;
    logic [CW-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    parity_frame_checker #(
        .DATA_BITS (DB),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .sof        (sof),
        .odd_mode   (odd_mode),
        .clr_cnt    (clr_cnt),
        .z          (z),
        .data_out   (data_out),
        .frame_done (frame_done),
        .parity_err (parity_err),
        .sync_err   (sync_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic s, input logic clr);
        bit_in    = b;
        sof       = s;
        clr_cnt   = clr;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        sof       = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // odd_mode is flipped after sof to confirm the mode is held per frame.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic m, input logic clr);
        logic [7:0] dv;
        dv       = d;
        odd_mode = m;
        send_bit(dv[0], 1'b1, 1'b0);
        odd_mode = ~m;
        for (int i = 1; i < 8; i++) begin
            send_bit(dv[i], 1'b0, 1'b0);
        end
        send_bit(p, 1'b0, clr);
        odd_mode = m;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic perr, input logic [3:0] cnt);
        check({tag, "_done"}, 32'(frame_done), 32'd1);
        check({tag, "_data"}, 32'(data_out), 32'(d));
        check({tag, "_perr"}, 32'(parity_err), 32'(perr));
        check({tag, "_cnt"}, 32'(err_cnt), 32'(cnt));
        check({tag, "_z"}, 32'(z), 32'd0);
    endtask

    initial begin
        logic [7:0] vec;
        logic       zexp;
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        sof       = 1'b0;
        odd_mode  = 1'b0;
        clr_cnt   = 1'b0;
        repeat (2) idle_cycle();
        check("rst_z", 32'(z), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_serr", 32'(sync_err), 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // Even mode, 0xA5, parity 0: clean frame
        odd_mode = 1'b0;
        send_bit(1'b1, 1'b1, 1'b0);
        check("a5_z_b0", 32'(z), 32'd1);
        send_bit(1'b0, 1'b0, 1'b0);
        check("a5_z_b1", 32'(z), 32'd1);
        send_bit(1'b1, 1'b0, 1'b0);
        check("a5_z_b2", 32'(z), 32'd0);
        vec = 8'hA5;
        for (int i = 3; i < 8; i++) send_bit(vec[i], 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        check_frame("even_a5", 8'hA5, 1'b0, 4'd0);
        idle_cycle();
        check("done_pulse_end", 32'(frame_done), 32'd0);

        // Odd mode, wrong then right parity
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check_frame("odd_a5_bad", 8'hA5, 1'b1, 4'd1);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check_frame("odd_a5_good", 8'hA5, 1'b0, 4'd1);

        // Abort after 3 data bits; the aborting sof bit begins 0x3C
        odd_mode = 1'b0;
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        vec = 8'h3C;
        send_bit(vec[0], 1'b1, 1'b0);
        check("abort_serr", 32'(sync_err), 32'd1);
        check("abort_done", 32'(frame_done), 32'd0);
        check("abort_data", 32'(data_out), 32'hA5);
        send_bit(vec[1], 1'b0, 1'b0);
        check("abort_serr_end", 32'(sync_err), 32'd0);
        for (int i = 2; i < 8; i++) send_bit(vec[i], 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        check_frame("after_abort_3c", 8'h3C, 1'b0, 4'd1);
        check("after_abort_serr", 32'(sync_err), 32'd0);

        // Saturation: clear, then 17 errored frames, then clear during an 18th error
        clr_cnt = 1'b1;
        idle_cycle();
        clr_cnt = 1'b0;
        check("clr_only", 32'(err_cnt), 32'd0);
        for (int f = 0; f < 17; f++) begin
            send_frame(8'h01, 1'b0, 1'b0, 1'b0);
            if (f == 14) check("sat_15", 32'(err_cnt), 32'd15);
        end
        check("sat_17", 32'(err_cnt), 32'd15);
        check("sat_17_perr", 32'(parity_err), 32'd1);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        check("clr_prio_cnt", 32'(err_cnt), 32'd0);
        check("clr_prio_perr", 32'(parity_err), 32'd1);

        // 0xFF with valid every third cycle and garbage in the gaps
        zexp = 1'b0;
        for (int i = 0; i < 9; i++) begin
            for (int g = 0; g < 2; g++) begin
                bit_in = (i == 8) ? 1'b1 : 1'b0;
                sof    = 1'b1;
                idle_cycle();
                check("gap_z", 32'(z), 32'(zexp));
            end
            sof = 1'b0;
            if (i < 8) begin
                send_bit(1'b1, (i == 0), 1'b0);
                zexp = ~zexp;
                check("gapped_z", 32'(z), 32'(zexp));
            end else begin
                send_bit(1'b0, 1'b0, 1'b0);
            end
        end
        check_frame("gapped_ff", 8'hFF, 1'b0, 4'd0);

        // Async reset mid-frame
        send_frame(8'h01, 1'b0, 1'b0, 1'b0);
        check("pre_rst_cnt", 32'(err_cnt), 32'd1);
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        check("pre_rst_z", 32'(z), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_z", 32'(z), 32'd0);
        check("async_rst_data", 32'(data_out), 32'd0);
        check("async_rst_cnt", 32'(err_cnt), 32'd0);
        check("async_rst_done", 32'(frame_done), 32'd0);
        idle_cycle();
        rst_n = 1'b1;
        idle_cycle();
        send_bit(1'b1, 1'b0, 1'b0);
        check("post_rst_ignored_z", 32'(z), 32'd0);
        check("post_rst_ignored_done", 32'(frame_done), 32'd0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check_frame("post_rst_a5", 8'hA5, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
